// File: rtl/add8_err_sweeper.sv
// ============================================================================
// Module   : add8_err_sweeper
// Purpose  : Sweeps every operand pair into an external approximate adder and
//            accumulates error-count, |e|, e^2 and worst-case error metrics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add8_err_sweeper #(
    parameter int W       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o,
    input  logic [W:0]     o_i,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   err_cnt,
    output logic [3*W:0]   sum_abs,
    output logic [4*W+1:0] sum_sq,
    output logic [W:0]     wce
);

    localparam logic [2*W-1:0] c_last_idx   = '1;
    localparam logic [2:0]     c_drain_last = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start_ok;
    logic [2*W-1:0]   r_index;
    logic [2:0]       r_drain;

    logic             w_v0;
    logic [W:0]       w_s0;
    logic             w_v;
    logic [W:0]       w_s;
    logic [W:0]       w_e;
    logic [2*W+1:0]   w_e_x;
    logic [2*W+1:0]   w_sq;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                if (r_index == c_last_idx)
                    w_state_nxt = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == c_drain_last) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_index <= '0;
                r_drain <= '0;
            end else if ((r_state == S_SWEEP) && (r_index != c_last_idx)) begin
                r_index <= r_index + 1'b1;
            end else if (r_state == S_DRAIN) begin
                r_drain <= r_drain + 1'b1;
            end
        end
    end

    // B is the inner loop; the index register doubles as the operand register
    assign a_o  = r_index[2*W-1:W];
    assign b_o  = r_index[W-1:0];
    assign busy = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------------
    // Exact-sum delay pipe, aligned with the adder's latency
    // ------------------------------------------------------------------------
    assign w_v0 = (r_state == S_SWEEP);
    assign w_s0 = {1'b0, a_o} + {1'b0, b_o};

    generate
        if (DUT_LAT == 0) begin : g_lat0
            assign w_v = w_v0;
            assign w_s = w_s0;
        end else begin : g_latn
            logic [DUT_LAT-1:0] r_vp;
            logic [W:0]         r_sp [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vp <= '0;
                    for (int i = 0; i < DUT_LAT; i++) r_sp[i] <= '0;
                end else begin
                    r_vp[0] <= w_v0;
                    r_sp[0] <= w_s0;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_vp[i] <= r_vp[i-1];
                        r_sp[i] <= r_sp[i-1];
                    end
                end
            end

            assign w_v = r_vp[DUT_LAT-1];
            assign w_s = r_sp[DUT_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Error magnitude and metric accumulation
    // ------------------------------------------------------------------------
    assign w_e   = (o_i >= w_s) ? (o_i - w_s) : (w_s - o_i);
    assign w_e_x = {{(W+1){1'b0}}, w_e};
    assign w_sq  = w_e_x * w_e_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            sum_abs <= '0;
            sum_sq  <= '0;
            wce     <= '0;
        end else if (w_start_ok) begin
            err_cnt <= '0;
            sum_abs <= '0;
            sum_sq  <= '0;
            wce     <= '0;
        end else if (w_v) begin
            err_cnt <= err_cnt + {{(2*W){1'b0}}, |w_e};
            sum_abs <= sum_abs + {{(2*W){1'b0}}, w_e};
            sum_sq  <= sum_sq + {{(2*W){1'b0}}, w_sq};
            if (w_e > wce) wce <= w_e;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add8_err_sweeper.sv
// ============================================================================
// Module   : tb_add8_err_sweeper
// Purpose  : Drives two sweepers (latency 0 and 3) against behavioural adder
//            models and checks metrics and timing against a loop-based reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add8_err_sweeper;

    localparam int W    = 4;
    localparam int N    = 1 << (2*W);
    localparam int LAT3 = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start0, start3;
    logic [W-1:0]   a_o0, b_o0, a_o3, b_o3;
    logic [W:0]     o_i0, o_i3;
    logic           busy0, done0, busy3, done3;
    logic [2*W:0]   err_cnt0, err_cnt3;
    logic [3*W:0]   sum_abs0, sum_abs3;
    logic [4*W+1:0] sum_sq0, sum_sq3;
    logic [W:0]     wce0, wce3;

    int             model_mode = 0;
    logic [W:0]     lut [N];
    logic [W:0]     p3 [LAT3];

    longint         exp_err, exp_abs, exp_sq, exp_wce;
    int             n_checks = 0;
    int             n_fail   = 0;

    always #5 clk = ~clk;

    add8_err_sweeper #(.W(W), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_o(a_o0), .b_o(b_o0), .o_i(o_i0),
        .busy(busy0), .done(done0),
        .err_cnt(err_cnt0), .sum_abs(sum_abs0), .sum_sq(sum_sq0), .wce(wce0)
    );

    add8_err_sweeper #(.W(W), .DUT_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_o(a_o3), .b_o(b_o3), .o_i(o_i3),
        .busy(busy3), .done(done3),
        .err_cnt(err_cnt3), .sum_abs(sum_abs3), .sum_sq(sum_sq3), .wce(wce3)
    );

    // Behavioural approximate-adder models
    function automatic logic [W:0] model_fn(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1:       return s ^ 1;
            2:       return '0;
            3:       return lut[{a, b}];
            default: return s;
        endcase
    endfunction

    assign o_i0 = model_fn(model_mode, a_o0, b_o0);

    always @(posedge clk) begin
        p3[0] <= model_fn(model_mode, a_o3, b_o3);
        for (int i = 1; i < LAT3; i++) p3[i] <= p3[i-1];
    end
    assign o_i3 = p3[LAT3-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compute_ref(input int m);
        int s, o, e;
        exp_err = 0; exp_abs = 0; exp_sq = 0; exp_wce = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                s = a + b;
                o = int'(model_fn(m, W'(a), W'(b)));
                e = (o > s) ? o - s : s - o;
                if (e != 0) exp_err++;
                exp_abs += e;
                exp_sq  += longint'(e) * e;
                if (e > exp_wce) exp_wce = e;
            end
        end
    endtask

    task automatic fill_lut();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0)
                lut[i] = (W+1)'($urandom_range((1 << (W+1)) - 1));
            else
                lut[i] = (W+1)'((i >> W) + (i % (1 << W)));
        end
    endtask

    // Caller is at a negedge; returns at a negedge with both DUTs in DONE
    task automatic run_sweep(input int m, input bit inject);
        int b0_n, b3_n, d0_at, d3_at;
        b0_n = 0; b3_n = 0; d0_at = 0; d3_at = 0;
        model_mode = m;
        compute_ref(m);
        start0 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= N + 12; c++) begin
            start0 = 1'b0;
            start3 = 1'b0;
            if (c == 1) begin
                check("clr_err0", 64'(err_cnt0), 0);
                check("clr_sq3", 64'(sum_sq3), 0);
                check("first_pair0", 64'({a_o0, b_o0}), 0);
            end
            if (c == 101) check("pair100_3", 64'({a_o3, b_o3}), 100);
            if (c == N)   check("last_pair0", 64'({a_o0, b_o0}), N - 1);
            if (busy0) b0_n++;
            if (busy3) b3_n++;
            if (done0 && d0_at == 0) d0_at = c;
            if (done3 && d3_at == 0) d3_at = c;
            if (inject) begin
                if (c == 100) begin start0 = 1'b1; start3 = 1'b1; end
                if (c == N)     start0 = 1'b1;
                if (c == N + 2) start3 = 1'b1;
            end
            if (d0_at != 0 && d3_at != 0) break;
            @(negedge clk);
        end
        check("done_at0", 64'(d0_at), N + 1);
        check("done_at3", 64'(d3_at), N + LAT3 + 1);
        check("busy_cyc0", 64'(b0_n), N);
        check("busy_cyc3", 64'(b3_n), N + LAT3);
        check("err_cnt0", 64'(err_cnt0), exp_err);
        check("sum_abs0", 64'(sum_abs0), exp_abs);
        check("sum_sq0",  64'(sum_sq0),  exp_sq);
        check("wce0",     64'(wce0),     exp_wce);
        check("err_cnt3", 64'(err_cnt3), exp_err);
        check("sum_abs3", 64'(sum_abs3), exp_abs);
        check("sum_sq3",  64'(sum_sq3),  exp_sq);
        check("wce3",     64'(wce3),     exp_wce);
        check("hold_pair3", 64'({a_o3, b_o3}), N - 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy0"}, 64'(busy0), 0);
        check({tag, "_done0"}, 64'(done0), 0);
        check({tag, "_err0"},  64'(err_cnt0), 0);
        check({tag, "_abs0"},  64'(sum_abs0), 0);
        check({tag, "_pair0"}, 64'({a_o0, b_o0}), 0);
        check({tag, "_busy3"}, 64'(busy3), 0);
        check({tag, "_done3"}, 64'(done3), 0);
        check({tag, "_sq3"},   64'(sum_sq3), 0);
        check({tag, "_wce3"},  64'(wce3), 0);
        check({tag, "_pair3"}, 64'({a_o3, b_o3}), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        fill_lut();
        repeat (3) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b1);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);
        run_sweep(3, 1'b0);
        fill_lut();
        run_sweep(3, 1'b1);

        // Abort mid-sweep with errors already accumulated
        model_mode = 1;
        start0 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        repeat (150) @(negedge clk);
        check("pre_rst_err0", 64'(err_cnt0 != 0), 1);
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
